ex_stage: RTL and testbench

Registered, handshaked RV32 execute stage sitting between ID and MEM. It computes full RV32I ALU results, load/store address and size, and branch/jump resolution, then holds the result in an output pipeline register. An optional iterative multiply/divide unit (RV32M) stalls the stage for multi-cycle operations. Forwarding outputs are driven from the output register so ID can bypass the register file.

---
 rtl/ex_stage.sv | 373 +++++++++++++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: registered, handshaked RV32I execute stage between ID and MEM.
// Computes ALU results, load/store address and size, and branch/jump
// resolution into a single output register; forwarding taps that register.
// Optional RV32M iterative multiply/divide is built when EX_MULDIV_EN is
// defined; without it the stage is always single-cycle and RV32M encodings
// become bubbles.
//
// Ports:
//   clk, rst (sync, active-high), flush (kills held and in-flight work)
//   in_valid/in_ready       : ID handshake; pc_i, reg1_i, reg2_i, imm_i,
//                             opcode_i, funct3_i, funct7_i, wd_i, wreg_i
//   out_valid/out_ready     : MEM handshake; wd_o, wreg_o, wdata_o, maddr_o,
//                             read_o, write_o, br_taken_o, br_target_o
//   for_valid_o/for_addr_o/for_data_o : bypass to ID
module ex_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [RA_W-1:0] wd_i,
    input  logic            wreg_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RA_W-1:0] wd_o,
    output logic            wreg_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] maddr_o,
    output logic [2:0]      read_o,
    output logic [1:0]      write_o,
    output logic            br_taken_o,
    output logic [XLEN-1:0] br_target_o,
    output logic            for_valid_o,
    output logic [RA_W-1:0] for_addr_o,
    output logic [XLEN-1:0] for_data_o
);

    localparam int unsigned SH_W  = $clog2(XLEN);
    localparam int unsigned CNT_W = SH_W + 1;
    localparam int unsigned DW    = 2 * XLEN;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_MULDIV = 1'b1;

    typedef struct packed {
        logic [RA_W-1:0] wd;
        logic            wreg;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] maddr;
        logic [2:0]      read;
        logic [1:0]      write;
        logic            br_taken;
        logic [XLEN-1:0] br_target;
    } ex_res_t;

    logic [0:0] state, state_nxt;
    logic       out_valid_q;
    ex_res_t    out_q;
    ex_res_t    dec_res;
    ex_res_t    md_res;
    logic       dec_md;
    logic       md_done;
    logic       accept;

    logic [XLEN-1:0] op_b, alu_res, addr_sum;
    logic [SH_W-1:0] shamt;
    logic            is_op, f7_zero, f7_alt, alu_ok, br_cond, br_ok;

    assign in_ready = !rst && (state == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    // ALU and branch comparator shared by OP and OP-IMM
    always_comb begin
        is_op    = (opcode_i == OPC_OP);
        op_b     = is_op ? reg2_i : imm_i;
        shamt    = op_b[SH_W-1:0];
        f7_zero  = (funct7_i == 7'b0000000);
        f7_alt   = (funct7_i == 7'b0100000);
        addr_sum = reg1_i + imm_i;
        alu_res  = '0;
        alu_ok   = 1'b1;
        br_cond  = 1'b0;
        br_ok    = 1'b1;
        case (funct3_i)
            3'b000: begin
                alu_res = (is_op && f7_alt) ? reg1_i - op_b : reg1_i + op_b;
                alu_ok  = !is_op || f7_zero || f7_alt;
            end
            3'b001: begin
                alu_res = reg1_i << shamt;
                alu_ok  = f7_zero;
            end
            3'b010: begin
                alu_res = XLEN'($signed(reg1_i) < $signed(op_b));
                alu_ok  = !is_op || f7_zero;
            end
            3'b011: begin
                alu_res = XLEN'(reg1_i < op_b);
                alu_ok  = !is_op || f7_zero;
            end
            3'b100: begin
                alu_res = reg1_i ^ op_b;
                alu_ok  = !is_op || f7_zero;
            end
            3'b101: begin
                alu_res = f7_alt ? XLEN'($signed(reg1_i) >>> shamt) : reg1_i >> shamt;
                alu_ok  = f7_zero || f7_alt;
            end
            3'b110: begin
                alu_res = reg1_i | op_b;
                alu_ok  = !is_op || f7_zero;
            end
            default: begin
                alu_res = reg1_i & op_b;
                alu_ok  = !is_op || f7_zero;
            end
        endcase
        case (funct3_i)
            3'b000:  br_cond = (reg1_i == reg2_i);
            3'b001:  br_cond = (reg1_i != reg2_i);
            3'b100:  br_cond = ($signed(reg1_i) <  $signed(reg2_i));
            3'b101:  br_cond = ($signed(reg1_i) >= $signed(reg2_i));
            3'b110:  br_cond = (reg1_i <  reg2_i);
            3'b111:  br_cond = (reg1_i >= reg2_i);
            default: br_ok   = 1'b0;
        endcase
    end

    // Opcode decode into the output payload; anything unrecognised stays a bubble
    always_comb begin
        dec_res    = '0;
        dec_res.wd = wd_i;
        dec_md     = 1'b0;
        case (opcode_i)
            OPC_LUI: begin
                dec_res.wreg  = wreg_i;
                dec_res.wdata = imm_i;
            end
            OPC_AUIPC: begin
                dec_res.wreg  = wreg_i;
                dec_res.wdata = pc_i + imm_i;
            end
            OPC_JAL: begin
                dec_res.wreg      = wreg_i;
                dec_res.wdata     = pc_i + XLEN'(4);
                dec_res.br_taken  = 1'b1;
                dec_res.br_target = pc_i + imm_i;
            end
            OPC_JALR: begin
                if (funct3_i == 3'b000) begin
                    dec_res.wreg      = wreg_i;
                    dec_res.wdata     = pc_i + XLEN'(4);
                    dec_res.br_taken  = 1'b1;
                    dec_res.br_target = addr_sum & ~XLEN'(1);
                end
            end
            OPC_BRANCH: begin
                if (br_ok) begin
                    dec_res.br_taken  = br_cond;
                    dec_res.br_target = pc_i + imm_i;
                end
            end
            OPC_LOAD: begin
                case (funct3_i)
                    3'b000:  dec_res.read = 3'b001;
                    3'b001:  dec_res.read = 3'b010;
                    3'b010:  dec_res.read = 3'b011;
                    3'b100:  dec_res.read = 3'b100;
                    3'b101:  dec_res.read = 3'b101;
                    default: dec_res.read = 3'b000;
                endcase
                if (dec_res.read != 3'b000) begin
                    dec_res.wreg  = wreg_i;
                    dec_res.maddr = addr_sum;
                end
            end
            OPC_STORE: begin
                case (funct3_i)
                    3'b000:  dec_res.write = 2'b01;
                    3'b001:  dec_res.write = 2'b10;
                    3'b010:  dec_res.write = 2'b11;
                    default: dec_res.write = 2'b00;
                endcase
                if (dec_res.write != 2'b00) begin
                    dec_res.maddr = addr_sum;
                    dec_res.wdata = reg2_i;
                end
            end
            OPC_OPIMM: begin
                if (alu_ok) begin
                    dec_res.wreg  = wreg_i;
                    dec_res.wdata = alu_res;
                end
            end
            OPC_OP: begin
                if (funct7_i == 7'b0000001) begin
`ifdef EX_MULDIV_EN
                    dec_md = 1'b1;
`endif
                end else if (alu_ok) begin
                    dec_res.wreg  = wreg_i;
                    dec_res.wdata = alu_res;
                end
            end
            default: ;
        endcase
    end

`ifdef EX_MULDIV_EN
    // Iterative RV32M: operands reduced to magnitudes, sign applied at the end.
    // md_acc holds {hi, multiplier} for multiply and {remainder, quotient} for divide.
    logic [CNT_W-1:0] md_cnt;
    logic [DW-1:0]    md_acc, md_step, md_prod;
    logic [XLEN-1:0]  md_b, md_a_raw, md_q, md_r;
    logic [XLEN-1:0]  ld_a_mag, ld_b_mag;
    logic [2:0]       md_f3;
    logic             md_neg_q, md_neg_r, md_bzero, ld_a_sgn, ld_b_sgn;
    logic [RA_W-1:0]  md_wd;
    logic             md_wreg;
    logic [XLEN:0]    mul_sum, div_r, div_trial;

    always_comb begin
        ld_a_sgn = reg1_i[XLEN-1] && (funct3_i == 3'b001 || funct3_i == 3'b010 ||
                                      funct3_i == 3'b100 || funct3_i == 3'b110);
        ld_b_sgn = reg2_i[XLEN-1] && (funct3_i == 3'b001 || funct3_i == 3'b100 ||
                                      funct3_i == 3'b110);
        ld_a_mag = ld_a_sgn ? -reg1_i : reg1_i;
        ld_b_mag = ld_b_sgn ? -reg2_i : reg2_i;
    end

    always_comb begin
        mul_sum   = {1'b0, md_acc[DW-1:XLEN]} + (md_acc[0] ? {1'b0, md_b} : '0);
        div_r     = {md_acc[DW-1:XLEN], md_acc[XLEN-1]};
        div_trial = div_r - {1'b0, md_b};
        if (!md_f3[2]) begin
            md_step = {mul_sum, md_acc[XLEN-1:1]};
        end else if (!div_trial[XLEN]) begin
            md_step = {div_trial[XLEN-1:0], md_acc[XLEN-2:0], 1'b1};
        end else begin
            md_step = {div_r[XLEN-1:0], md_acc[XLEN-2:0], 1'b0};
        end
    end

    // Final sign fix-up and divide-by-zero override
    always_comb begin
        md_prod = md_neg_q ? -md_acc : md_acc;
        md_q    = md_neg_q ? -md_acc[XLEN-1:0] : md_acc[XLEN-1:0];
        md_r    = md_neg_r ? -md_acc[DW-1:XLEN] : md_acc[DW-1:XLEN];
        if (md_bzero) begin
            md_q = '1;
            md_r = md_a_raw;
        end
        md_res      = '0;
        md_res.wd   = md_wd;
        md_res.wreg = md_wreg;
        if (!md_f3[2]) begin
            md_res.wdata = (md_f3[1:0] == 2'b00) ? md_prod[XLEN-1:0] : md_prod[DW-1:XLEN];
        end else begin
            md_res.wdata = md_f3[1] ? md_r : md_q;
        end
    end

    assign md_done = (state == S_MULDIV) && (md_cnt == CNT_W'(XLEN)) &&
                     (!out_valid_q || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt   <= '0;
            md_acc   <= '0;
            md_b     <= '0;
            md_a_raw <= '0;
            md_f3    <= '0;
            md_neg_q <= 1'b0;
            md_neg_r <= 1'b0;
            md_bzero <= 1'b0;
            md_wd    <= '0;
            md_wreg  <= 1'b0;
        end else if (accept && dec_md) begin
            md_cnt   <= '0;
            md_acc   <= {{XLEN{1'b0}}, (funct3_i[2] ? ld_a_mag : ld_b_mag)};
            md_b     <= funct3_i[2] ? ld_b_mag : ld_a_mag;
            md_a_raw <= reg1_i;
            md_f3    <= funct3_i;
            md_neg_q <= ld_a_sgn ^ ld_b_sgn;
            md_neg_r <= ld_a_sgn;
            md_bzero <= funct3_i[2] && (reg2_i == '0);
            md_wd    <= wd_i;
            md_wreg  <= wreg_i;
        end else if (state == S_MULDIV && md_cnt != CNT_W'(XLEN)) begin
            md_acc <= md_step;
            md_cnt <= md_cnt + CNT_W'(1);
        end
    end
`else
    assign md_done = 1'b0;
    assign md_res  = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (accept && dec_md) state_nxt = S_MULDIV;
                S_MULDIV: if (md_done)          state_nxt = S_IDLE;
                default:                        state_nxt = S_IDLE;
            endcase
        end
    end

    // Output pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept && !dec_md) begin
            out_valid_q <= 1'b1;
            out_q       <= dec_res;
        end else if (md_done) begin
            out_valid_q <= 1'b1;
            out_q       <= md_res;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign wd_o        = out_q.wd;
    assign wreg_o      = out_q.wreg;
    assign wdata_o     = out_q.wdata;
    assign maddr_o     = out_q.maddr;
    assign read_o      = out_q.read;
    assign write_o     = out_q.write;
    assign br_taken_o  = out_q.br_taken;
    assign br_target_o = out_q.br_target;

    // Load data is not known here, so loads never forward
    assign for_valid_o = out_valid_q && out_q.wreg && (out_q.wd != '0) &&
                         (out_q.read == 3'b000);
    assign for_addr_o  = out_q.wd;
    assign for_data_o  = out_q.wdata;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] pc, reg1, reg2, imm;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [RA_W-1:0] wd;
    logic            wreg;
    logic            out_valid;
    logic            out_ready;
    logic [RA_W-1:0] wd_o;
    logic            wreg_o;
    logic [XLEN-1:0] wdata_o, maddr_o, br_target_o, for_data_o;
    logic [2:0]      read_o;
    logic [1:0]      write_o;
    logic            br_taken_o;
    logic            for_valid_o;
    logic [RA_W-1:0] for_addr_o;

    int total = 0;
    int bad   = 0;

    ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc), .reg1_i(reg1), .reg2_i(reg2), .imm_i(imm),
        .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
        .wd_i(wd), .wreg_i(wreg),
        .out_valid(out_valid), .out_ready(out_ready),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .maddr_o(maddr_o),
        .read_o(read_o), .write_o(write_o),
        .br_taken_o(br_taken_o), .br_target_o(br_target_o),
        .for_valid_o(for_valid_o), .for_addr_o(for_addr_o), .for_data_o(for_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [31:0] p, input logic [4:0] d, input logic we);
        in_valid = 1'b1;
        opcode   = opc;
        funct3   = f3;
        funct7   = f7;
        reg1     = r1;
        reg2     = r2;
        imm      = im;
        pc       = p;
        wd       = d;
        wreg     = we;
    endtask

    initial begin
        int n;
        logic seen;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pc = '0; reg1 = '0; reg2 = '0; imm = '0;
        opcode = '0; funct3 = '0; funct7 = '0; wd = '0; wreg = 1'b0;
        tick;
        tick;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_for_valid", 32'(for_valid_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // ADDI 5 + -3
        drive(OPC_OPIMM, 3'b000, 7'h7F, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'h0, 5'd1, 1'b1);
        tick;
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_wdata", wdata_o, 32'd2);
        chk("addi_for_valid", 32'(for_valid_o), 32'd1);
        chk("addi_for_addr", 32'(for_addr_o), 32'd1);

        drive(OPC_OP, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 5'd2, 1'b1);
        tick;
        chk("slt", wdata_o, 32'd1);
        chk("slt_valid", 32'(out_valid), 32'd1);

        drive(OPC_OP, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 5'd2, 1'b1);
        tick;
        chk("sltu", wdata_o, 32'd0);

        drive(OPC_OP, 3'b101, 7'h20, 32'h8000_0000, 32'd4, 32'd0, 32'h0, 5'd2, 1'b1);
        tick;
        chk("sra", wdata_o, 32'hF800_0000);

        drive(OPC_OP, 3'b101, 7'h00, 32'h8000_0000, 32'd4, 32'd0, 32'h0, 5'd2, 1'b1);
        tick;
        chk("srl", wdata_o, 32'h0800_0000);

        drive(OPC_OP, 3'b000, 7'h20, 32'd3, 32'd5, 32'd0, 32'h0, 5'd2, 1'b1);
        tick;
        chk("sub", wdata_o, 32'hFFFF_FFFE);

        drive(OPC_BRANCH, 3'b100, 7'h00, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 5'd0, 1'b0);
        tick;
        chk("blt_taken", 32'(br_taken_o), 32'd1);
        chk("blt_target", br_target_o, 32'h120);
        chk("blt_wreg", 32'(wreg_o), 32'd0);

        drive(OPC_BRANCH, 3'b111, 7'h00, 32'd1, 32'd2, 32'h20, 32'h100, 5'd0, 1'b0);
        tick;
        chk("bgeu_not_taken", 32'(br_taken_o), 32'd0);

        drive(OPC_JALR, 3'b000, 7'h00, 32'h203, 32'd0, 32'd0, 32'h40, 5'd1, 1'b1);
        tick;
        chk("jalr_target", br_target_o, 32'h202);
        chk("jalr_link", wdata_o, 32'h44);
        chk("jalr_taken", 32'(br_taken_o), 32'd1);

        drive(OPC_JAL, 3'b000, 7'h00, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'h200, 5'd1, 1'b1);
        tick;
        chk("jal_target", br_target_o, 32'h1F8);
        chk("jal_link", wdata_o, 32'h204);

        drive(OPC_LOAD, 3'b010, 7'h7F, 32'h1000, 32'd0, 32'hFFFF_FFFC, 32'h0, 5'd3, 1'b1);
        tick;
        chk("lw_addr", maddr_o, 32'hFFC);
        chk("lw_read", 32'(read_o), 32'd3);
        chk("lw_wdata", wdata_o, 32'd0);
        chk("lw_no_fwd", 32'(for_valid_o), 32'd0);
        chk("lw_wreg", 32'(wreg_o), 32'd1);

        drive(OPC_STORE, 3'b001, 7'h00, 32'h2000, 32'hABCD, 32'd6, 32'h0, 5'd0, 1'b0);
        tick;
        chk("sh_addr", maddr_o, 32'h2006);
        chk("sh_write", 32'(write_o), 32'd2);
        chk("sh_data", wdata_o, 32'hABCD);
        chk("sh_wreg", 32'(wreg_o), 32'd0);

        drive(7'b1111111, 3'b000, 7'h00, 32'd1, 32'd1, 32'd1, 32'h0, 5'd4, 1'b1);
        tick;
        chk("unk_valid", 32'(out_valid), 32'd1);
        chk("unk_wreg", 32'(wreg_o), 32'd0);
        chk("unk_rw", {27'd0, read_o, write_o}, 32'd0);
        chk("unk_br", 32'(br_taken_o), 32'd0);

`ifndef EX_MULDIV_EN
        // RV32M encoding is a single-cycle bubble without the unit
        drive(OPC_OP, 3'b000, 7'h01, 32'd3, 32'd4, 32'd0, 32'h0, 5'd4, 1'b1);
        tick;
        chk("m_bubble_valid", 32'(out_valid), 32'd1);
        chk("m_bubble_wreg", 32'(wreg_o), 32'd0);
        chk("m_bubble_ready", 32'(in_ready), 32'd1);
`endif

        // Backpressure: hold output three cycles with the next instruction waiting
        drive(OPC_LUI, 3'b000, 7'h00, 32'd0, 32'd0, 32'h1234_5000, 32'h0, 5'd2, 1'b1);
        tick;
        chk("lui", wdata_o, 32'h1234_5000);
        out_ready = 1'b0;
        drive(OPC_AUIPC, 3'b000, 7'h00, 32'd0, 32'd0, 32'h2000, 32'h1000, 5'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick;
            chk("bp_hold_data", wdata_o, 32'h1234_5000);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick;
        chk("auipc", wdata_o, 32'h3000);
        chk("auipc_wd", 32'(wd_o), 32'd4);
        chk("auipc_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick;
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Flush kills held result and same-cycle acceptance
        drive(OPC_OPIMM, 3'b000, 7'h00, 32'd1, 32'd0, 32'd1, 32'h0, 5'd1, 1'b1);
        tick;
        chk("pre_flush_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_for_valid", 32'(for_valid_o), 32'd0);

`ifdef EX_MULDIV_EN
        drive(OPC_OP, 3'b100, 7'h01, 32'd7, 32'd0, 32'd0, 32'h0, 5'd5, 1'b1);
        tick;
        in_valid = 1'b0;
        chk("div_busy_ready", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            tick;
            n++;
        end
        chk("div_latency", 32'(n), 32'd33);
        chk("div_by_zero", wdata_o, 32'hFFFF_FFFF);
        chk("div_wd", 32'(wd_o), 32'd5);

        drive(OPC_OP, 3'b110, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h0, 5'd5, 1'b1);
        tick;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick;
            n++;
        end
        chk("rem_ovf_latency", 32'(n), 32'd33);
        chk("rem_ovf", wdata_o, 32'd0);

        drive(OPC_OP, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h0, 5'd5, 1'b1);
        tick;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick;
            n++;
        end
        chk("mulhu_latency", 32'(n), 32'd33);
        chk("mulhu", wdata_o, 32'hFFFF_FFFE);

        drive(OPC_OP, 3'b100, 7'h01, 32'd100, 32'd7, 32'd0, 32'h0, 5'd5, 1'b1);
        tick;
        in_valid = 1'b0;
        repeat (9) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("md_flush_valid", 32'(out_valid), 32'd0);
        chk("md_flush_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            tick;
            if (out_valid) seen = 1'b1;
        end
        chk("md_flush_no_result", 32'(seen), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
